// File: rtl/i2c_ram_ctrl.sv
// Bridges an I2C slave byte interface to a single-port RAM with auto-incrementing pointer.
// Writes strobe one cycle after the byte arrives; reads return the byte three cycles after byte_req_in.
module i2c_ram_ctrl #(
  parameter int ADDR_W  = 7,
  parameter int WP_BASE = 64
) (
  input  logic              clock_in,
  input  logic              reset_n_in,
  input  logic              start_in,
  input  logic              rw_in,
  input  logic              stop_in,
  input  logic              byte_valid_in,
  input  logic [7:0]        byte_in,
  input  logic              byte_req_in,
  input  logic              wp_in,
  input  logic [7:0]        ram_data_in,
  output logic              wr_en_out,
  output logic              rd_en_out,
  output logic [ADDR_W-1:0] addr_out,
  output logic [7:0]        data_out,
  output logic [7:0]        byte_out,
  output logic              byte_out_valid_out,
  output logic              nack_out,
  output logic              busy_out
);

  typedef enum logic [2:0] {
    IDLE,
    PTR,
    WRITE,
    READ,
    RD_ISSUE,
    RD_WAIT
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        data_q, data_d;
  logic [7:0]        byte_q, byte_d;
  logic              wr_en_q, wr_en_d;
  logic              rd_en_q, rd_en_d;
  logic              bvld_q, bvld_d;
  logic              nack_q, nack_d;

  logic [ADDR_W-1:0] ptr_inc;
  logic              wp_hit;

  assign ptr_inc = ptr_q + ADDR_W'(1);
  assign wp_hit  = wp_in && (32'(ptr_q) >= 32'(WP_BASE));

  // start beats stop, stop beats data/request events
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    addr_d  = addr_q;
    data_d  = data_q;
    byte_d  = byte_q;
    wr_en_d = 1'b0;
    rd_en_d = 1'b0;
    bvld_d  = 1'b0;
    nack_d  = 1'b0;

    if (start_in) begin
      state_d = rw_in ? READ : PTR;
    end else if (stop_in) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        PTR: begin
          if (byte_valid_in) begin
            ptr_d   = byte_in[ADDR_W-1:0];
            state_d = WRITE;
          end
        end
        WRITE: begin
          if (byte_valid_in) begin
            ptr_d = ptr_inc;
            if (wp_hit) begin
              nack_d = 1'b1;
            end else begin
              wr_en_d = 1'b1;
              addr_d  = ptr_q;
              data_d  = byte_in;
            end
          end
        end
        READ: begin
          if (byte_req_in) begin
            rd_en_d = 1'b1;
            addr_d  = ptr_q;
            state_d = RD_ISSUE;
          end
        end
        RD_ISSUE: begin
          state_d = RD_WAIT;
        end
        RD_WAIT: begin
          byte_d  = ram_data_in;
          bvld_d  = 1'b1;
          ptr_d   = ptr_inc;
          state_d = READ;
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  always_ff @(posedge clock_in) begin
    if (!reset_n_in) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      byte_q  <= '0;
      wr_en_q <= 1'b0;
      rd_en_q <= 1'b0;
      bvld_q  <= 1'b0;
      nack_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      byte_q  <= byte_d;
      wr_en_q <= wr_en_d;
      rd_en_q <= rd_en_d;
      bvld_q  <= bvld_d;
      nack_q  <= nack_d;
    end
  end

  assign wr_en_out          = wr_en_q;
  assign rd_en_out          = rd_en_q;
  assign addr_out           = addr_q;
  assign data_out           = data_q;
  assign byte_out           = byte_q;
  assign byte_out_valid_out = bvld_q;
  assign nack_out           = nack_q;
  assign busy_out           = (state_q != IDLE);

endmodule

// File: tb/tb_i2c_ram_ctrl.sv
// Randomized transaction bench for i2c_ram_ctrl with a byte-level memory/pointer model.
module tb_i2c_ram_ctrl;

  localparam int AW    = 7;
  localparam int WPB   = 64;
  localparam int DEPTH = 128;

  logic          clock_in = 1'b0;
  logic          reset_n_in;
  logic          start_in, rw_in, stop_in, byte_valid_in, byte_req_in, wp_in;
  logic [7:0]    byte_in;
  logic [7:0]    ram_data_in;
  logic          wr_en_out, rd_en_out, byte_out_valid_out, nack_out, busy_out;
  logic [AW-1:0] addr_out;
  logic [7:0]    data_out, byte_out;

  int n_chk  = 0;
  int n_pass = 0;

  logic [7:0] ram     [DEPTH];
  logic [7:0] mdl_mem [DEPTH];
  int         mptr;
  bit         mbusy;

  i2c_ram_ctrl #(.ADDR_W(AW), .WP_BASE(WPB)) dut (
    .clock_in           (clock_in),
    .reset_n_in         (reset_n_in),
    .start_in           (start_in),
    .rw_in              (rw_in),
    .stop_in            (stop_in),
    .byte_valid_in      (byte_valid_in),
    .byte_in            (byte_in),
    .byte_req_in        (byte_req_in),
    .wp_in              (wp_in),
    .ram_data_in        (ram_data_in),
    .wr_en_out          (wr_en_out),
    .rd_en_out          (rd_en_out),
    .addr_out           (addr_out),
    .data_out           (data_out),
    .byte_out           (byte_out),
    .byte_out_valid_out (byte_out_valid_out),
    .nack_out           (nack_out),
    .busy_out           (busy_out)
  );

  always #5 clock_in = ~clock_in;

  function automatic logic [7:0] init_val(int i);
    return 8'((i * 37 + 5) & 255);
  endfunction

  // RAM returns data one cycle after rd_en_out; junk otherwise
  always @(posedge clock_in) begin
    if (!reset_n_in) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= init_val(i);
    end else if (wr_en_out) begin
      ram[addr_out] <= data_out;
    end
    ram_data_in <= rd_en_out ? ram[addr_out] : 8'($urandom);
  end

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // exp bits: {wr_en, rd_en, nack, byte_valid, busy}
  task automatic expect_out(string tag, logic [4:0] exp);
    check(tag, 32'({wr_en_out, rd_en_out, nack_out, byte_out_valid_out, busy_out}), 32'(exp));
  endtask

  task automatic tick();
    @(posedge clock_in);
    #1;
    start_in      = 1'b0;
    stop_in       = 1'b0;
    byte_valid_in = 1'b0;
    byte_req_in   = 1'b0;
    byte_in       = 8'($urandom);
  endtask

  task automatic model_reset();
    mptr  = 0;
    mbusy = 1'b0;
    for (int i = 0; i < DEPTH; i++) mdl_mem[i] = init_val(i);
  endtask

  task automatic do_stop();
    stop_in = 1'b1;
    tick();
    expect_out("stop", 5'b00000);
    mbusy = 1'b0;
  endtask

  task automatic wr_txn(int ptr, int nbytes, bit stop_at_end);
    logic [7:0] b;
    start_in = 1'b1;
    rw_in    = 1'b0;
    tick();
    expect_out("wr_start", 5'b00001);
    mbusy = 1'b1;
    byte_valid_in = 1'b1;
    byte_in       = {1'($urandom), 7'(ptr)};
    tick();
    expect_out("wr_ptr", 5'b00001);
    mptr = ptr % DEPTH;
    for (int k = 0; k < nbytes; k++) begin
      repeat ($urandom_range(0, 2)) begin
        tick();
        expect_out("wr_gap", 5'b00001);
      end
      b             = 8'($urandom);
      byte_valid_in = 1'b1;
      byte_in       = b;
      tick();
      if (wp_in && mptr >= WPB) begin
        expect_out("wr_nack", 5'b00101);
      end else begin
        expect_out("wr_strobe", 5'b10001);
        check("wr_addr", 32'(addr_out), 32'(mptr));
        check("wr_data", 32'(data_out), 32'(b));
        mdl_mem[mptr] = b;
      end
      mptr = (mptr + 1) % DEPTH;
    end
    if (stop_at_end) do_stop();
  endtask

  task automatic rd_one(bit abort);
    repeat ($urandom_range(0, 2)) begin
      byte_valid_in = 1'($urandom);
      tick();
      expect_out("rd_gap", 5'b00001);
    end
    byte_req_in = 1'b1;
    tick();
    expect_out("rd_issue", 5'b01001);
    check("rd_addr", 32'(addr_out), 32'(mptr));
    byte_req_in = 1'($urandom);
    tick();
    expect_out("rd_wait", 5'b00001);
    if (abort) begin
      stop_in = 1'b1;
      tick();
      expect_out("rd_abort", 5'b00000);
      mbusy = 1'b0;
    end else begin
      byte_req_in = 1'($urandom);
      tick();
      expect_out("rd_valid", 5'b00011);
      check("rd_byte", 32'(byte_out), 32'(mdl_mem[mptr]));
      mptr = (mptr + 1) % DEPTH;
    end
  endtask

  task automatic rd_txn(int n, bit abort_last, bit stop_at_end);
    start_in = 1'b1;
    rw_in    = 1'b1;
    tick();
    expect_out("rd_start", 5'b00001);
    mbusy = 1'b1;
    for (int i = 0; i < n; i++) rd_one(abort_last && (i == n - 1));
    if (mbusy && stop_at_end) do_stop();
  endtask

  task automatic idle_noise();
    if (mbusy) do_stop();
    repeat ($urandom_range(1, 3)) begin
      byte_valid_in = 1'($urandom);
      byte_req_in   = 1'($urandom);
      tick();
      expect_out("idle", 5'b00000);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n_in    = 1'b0;
    start_in      = 1'b0;
    rw_in         = 1'b0;
    stop_in       = 1'b0;
    byte_valid_in = 1'b0;
    byte_req_in   = 1'b0;
    wp_in         = 1'b0;
    byte_in       = 8'h00;
    model_reset();
    tick();
    tick();
    check("reset_outs", 32'({wr_en_out, rd_en_out, nack_out, byte_out_valid_out,
                             busy_out, addr_out, data_out, byte_out}), 32'(0));
    reset_n_in = 1'b1;
    tick();
    expect_out("post_reset", 5'b00000);

    // basic write, then pointer confirmed by current-address read
    wr_txn(8'h10, 2, 1'b1);
    rd_txn(1, 1'b0, 1'b1);

    // pointer wrap on read
    wr_txn(8'h7E, 1, 1'b1);
    rd_txn(2, 1'b0, 1'b1);

    // write protect boundary
    wp_in = 1'b1;
    wr_txn(8'h3F, 2, 1'b1);
    wp_in = 1'b0;
    rd_txn(1, 1'b0, 1'b1);

    // abort read one cycle after rd_en, pointer kept
    rd_txn(1, 1'b1, 1'b0);
    rd_txn(1, 1'b0, 1'b1);

    // start(read) beats a coincident byte in WRITE
    wr_txn(8'h20, 1, 1'b0);
    start_in      = 1'b1;
    rw_in         = 1'b1;
    byte_valid_in = 1'b1;
    tick();
    expect_out("prio_start", 5'b00001);
    rd_one(1'b0);
    do_stop();

    // reset in RD_WAIT
    start_in = 1'b1;
    rw_in    = 1'b1;
    tick();
    mbusy       = 1'b1;
    byte_req_in = 1'b1;
    tick();
    expect_out("rst_rd_issue", 5'b01001);
    tick();
    reset_n_in = 1'b0;
    tick();
    check("rst_mid_outs", 32'({wr_en_out, rd_en_out, nack_out, byte_out_valid_out,
                               busy_out, addr_out, data_out, byte_out}), 32'(0));
    reset_n_in = 1'b1;
    model_reset();
    tick();
    expect_out("rst_mid_after", 5'b00000);
    rd_txn(1, 1'b0, 1'b1);

    for (int it = 0; it < 200; it++) begin
      case ($urandom_range(0, 4))
        0: begin
          wp_in = 1'($urandom);
          wr_txn(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, 4)), 1'($urandom));
        end
        1: rd_txn(int'($urandom_range(1, 4)), ($urandom_range(0, 3) == 0), 1'($urandom));
        2: idle_noise();
        3: begin
          wr_txn(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, 2)), 1'b0);
          byte_valid_in = 1'b1;
          stop_in       = 1'b1;
          tick();
          expect_out("stop_vs_byte", 5'b00000);
          mbusy = 1'b0;
        end
        default: begin
          wr_txn(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, 2)), 1'b0);
          start_in      = 1'b1;
          rw_in         = 1'b1;
          byte_valid_in = 1'b1;
          tick();
          expect_out("rand_prio", 5'b00001);
          rd_one(1'b0);
        end
      endcase
    end
    idle_noise();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
